// File: rtl/dot_npu_pkg.sv
// Shared types and widths for the dot-product NPU blocks.
package dot_npu_pkg;

    typedef enum logic [2:0] {
        LOAD_A,
        LOAD_B,
        START,
        WAIT,
        RESULT,
        RECOVER
    } loader_state_t;

    localparam int unsigned VEC_W     = 128;
    localparam int unsigned DOT_RES_W = 32;

    typedef logic [7:0] elem_t;

endpackage

// File: rtl/dot_operand_loader.sv
// Streams two operand vectors into matrix_dot, sequences start/done/recovery and returns the result.
// Optional DOT_LOADER_TIMEOUT_EN: abort a WAIT that exceeds DONE_TIMEOUT cycles, set err_timeout_o.
module dot_operand_loader
    import dot_npu_pkg::*;
#(
    parameter int unsigned WORD_W       = 32,
    parameter int unsigned VEC_BYTES    = 16,
    parameter int unsigned START_HOLD   = 4,
    parameter int unsigned RECOVER_CYC  = 4,
    parameter int unsigned DONE_TIMEOUT = 1024
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 in_valid_i,
    output logic                 in_ready_o,
    input  logic [WORD_W-1:0]    in_data_i,
    output logic [VEC_W-1:0]     dot_a_o,
    output logic [VEC_W-1:0]     dot_b_o,
    output logic                 dot_start_o,
    output logic                 dot_rst_n_o,
    input  logic                 dot_done_i,
    input  logic [DOT_RES_W-1:0] dot_c_i,
    output logic                 res_valid_o,
    input  logic                 res_ready_i,
    output logic [DOT_RES_W-1:0] res_data_o,
    output logic                 busy_o,
    output logic                 err_timeout_o
);

    localparam int unsigned NumWords = (VEC_BYTES * 8) / WORD_W;
    localparam int unsigned CntW     = (NumWords > 1) ? $clog2(NumWords) : 1;
    localparam int unsigned HoldMax  = (START_HOLD > RECOVER_CYC) ? START_HOLD : RECOVER_CYC;
    localparam int unsigned HoldW    = $clog2(HoldMax + 1);

    localparam logic [CntW-1:0]  LastWord    = CntW'(NumWords - 1);
    localparam logic [HoldW-1:0] StartLoad   = HoldW'(START_HOLD - 1);
    localparam logic [HoldW-1:0] RecoverLoad = HoldW'(RECOVER_CYC - 1);

    loader_state_t        state_q, state_d;
    logic [CntW-1:0]      cnt_q, cnt_d;
    logic [HoldW-1:0]     hold_q, hold_d;
    logic [VEC_W-1:0]     a_q, a_d, b_q, b_d;
    logic                 res_valid_q, res_valid_d;
    logic [DOT_RES_W-1:0] res_data_q, res_data_d;
    logic                 alive_q;
    logic                 accept;
    logic                 tmo_hit;

`ifdef DOT_LOADER_TIMEOUT_EN
    localparam int unsigned TmoW = $clog2(DONE_TIMEOUT + 1);
    localparam logic [TmoW-1:0] TmoLast = TmoW'(DONE_TIMEOUT - 1);

    logic [TmoW-1:0] tmo_q, tmo_d;
    logic            err_q, err_d;

    // A done on the final allowed cycle still wins over the timeout.
    assign tmo_hit = (state_q == WAIT) && !dot_done_i && (tmo_q == TmoLast);

    always_comb begin
        tmo_d = '0;
        err_d = err_q | tmo_hit;
        if (state_q == WAIT) begin
            tmo_d = tmo_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            tmo_q <= '0;
            err_q <= 1'b0;
        end else begin
            tmo_q <= tmo_d;
            err_q <= err_d;
        end
    end

    assign err_timeout_o = err_q;
`else
    assign tmo_hit       = 1'b0;
    assign err_timeout_o = 1'b0;
`endif

    // Holds handshake outputs inactive for the cycle in which reset is applied.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            alive_q <= 1'b0;
        end else begin
            alive_q <= 1'b1;
        end
    end

    assign in_ready_o  = alive_q && ((state_q == LOAD_A) || (state_q == LOAD_B));
    assign accept      = in_valid_i && in_ready_o;
    assign dot_start_o = (state_q == START);
    assign dot_rst_n_o = alive_q && (state_q != RECOVER);
    assign dot_a_o     = a_q;
    assign dot_b_o     = b_q;
    assign res_valid_o = res_valid_q;
    assign res_data_o  = res_data_q;
    assign busy_o      = !((state_q == LOAD_A) && (cnt_q == '0));

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        hold_d      = hold_q;
        a_d         = a_q;
        b_d         = b_q;
        res_valid_d = res_valid_q;
        res_data_d  = res_data_q;
        unique case (state_q)
            LOAD_A: begin
                if (accept) begin
                    a_d[cnt_q*WORD_W +: WORD_W] = in_data_i;
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == LastWord) begin
                        cnt_d   = '0;
                        state_d = LOAD_B;
                    end
                end
            end
            LOAD_B: begin
                if (accept) begin
                    b_d[cnt_q*WORD_W +: WORD_W] = in_data_i;
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == LastWord) begin
                        cnt_d   = '0;
                        hold_d  = StartLoad;
                        state_d = START;
                    end
                end
            end
            START: begin
                hold_d = hold_q - 1'b1;
                if (hold_q == '0) begin
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (dot_done_i) begin
                    res_data_d  = dot_c_i;
                    res_valid_d = 1'b1;
                    state_d     = RESULT;
                end else if (tmo_hit) begin
                    hold_d  = RecoverLoad;
                    state_d = RECOVER;
                end
            end
            RESULT: begin
                if (res_ready_i) begin
                    res_valid_d = 1'b0;
                    hold_d      = RecoverLoad;
                    state_d     = RECOVER;
                end
            end
            RECOVER: begin
                hold_d = hold_q - 1'b1;
                if (hold_q == '0) begin
                    cnt_d   = '0;
                    state_d = LOAD_A;
                end
            end
            default: state_d = LOAD_A;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q     <= LOAD_A;
            cnt_q       <= '0;
            hold_q      <= '0;
            a_q         <= '0;
            b_q         <= '0;
            res_valid_q <= 1'b0;
            res_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            hold_q      <= hold_d;
            a_q         <= a_d;
            b_q         <= b_d;
            res_valid_q <= res_valid_d;
            res_data_q  <= res_data_d;
        end
    end

endmodule

// File: tb/tb_dot_operand_loader.sv
// Directed bench for dot_operand_loader; acts as host stream, result sink and matrix_dot stub.
module tb_dot_operand_loader;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [31:0]  in_data;
    logic [127:0] dot_a;
    logic [127:0] dot_b;
    logic         dot_start;
    logic         dot_rst_n;
    logic         dot_done;
    logic [31:0]  dot_c;
    logic         res_valid;
    logic         res_ready;
    logic [31:0]  res_data;
    logic         busy;
    logic         err_timeout;

    int n_run  = 0;
    int n_fail = 0;
    int start_rises = 0;
    logic start_prev = 1'b0;

    always #5 clk = ~clk;

    dot_operand_loader #(
        .WORD_W      (32),
        .VEC_BYTES   (16),
        .START_HOLD  (4),
        .RECOVER_CYC (4),
        .DONE_TIMEOUT(16)
    ) dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .in_valid_i   (in_valid),
        .in_ready_o   (in_ready),
        .in_data_i    (in_data),
        .dot_a_o      (dot_a),
        .dot_b_o      (dot_b),
        .dot_start_o  (dot_start),
        .dot_rst_n_o  (dot_rst_n),
        .dot_done_i   (dot_done),
        .dot_c_i      (dot_c),
        .res_valid_o  (res_valid),
        .res_ready_i  (res_ready),
        .res_data_o   (res_data),
        .busy_o       (busy),
        .err_timeout_o(err_timeout)
    );

    always @(posedge clk) begin
        start_prev <= dot_start;
        if (dot_start && !start_prev) start_rises <= start_rises + 1;
    end

    task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_run++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [31:0] w, input int gap);
        int waited = 0;
        repeat (gap) begin
            in_valid = 1'b0;
            step();
        end
        in_valid = 1'b1;
        in_data  = w;
        while (!in_ready && waited < 50) begin
            step();
            waited++;
        end
        check_eq("push_ready", in_ready, 1);
        step();
        in_valid = 1'b0;
    endtask

    task automatic load_op(input logic [127:0] a, input logic [127:0] b, input bit rnd);
        for (int k = 0; k < 4; k++) push(a[k*32 +: 32], rnd ? int'($urandom_range(0, 3)) : 0);
        for (int k = 0; k < 4; k++) push(b[k*32 +: 32], rnd ? int'($urandom_range(0, 3)) : 0);
    endtask

    // Counts cycles dot_start is high, starting on the cycle after the last B word.
    task automatic run_start(input string tag);
        int h = 0;
        check_eq({tag, "_start_rise"}, dot_start, 1);
        while (dot_start && h < 50) begin
            h++;
            step();
        end
        check_eq({tag, "_start_len"}, h, 4);
    endtask

    task automatic wait_recover(input string tag);
        int n = 0;
        while (!dot_rst_n && n < 50) begin
            n++;
            step();
        end
        check_eq({tag, "_recover_len"}, n, 4);
        check_eq({tag, "_ready_after"}, in_ready, 1);
    endtask

    function automatic logic [31:0] stub_dot(input logic [127:0] a, input logic [127:0] b);
        logic [31:0] s = 0;
        for (int i = 0; i < 16; i++) s += 32'(a[i*8 +: 8]) * 32'(b[i*8 +: 8]);
        return s;
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [127:0] a3, b3;
        int n;
        a3 = {32'h100f0e0d, 32'h0c0b0a09, 32'h08070605, 32'h04030201};
        b3 = {32'h01020304, 32'h05060708, 32'h090a0b0c, 32'h0d0e0f10};
        rst_n = 1'b0; in_valid = 1'b0; in_data = '0; res_ready = 1'b0;
        dot_done = 1'b0; dot_c = '0;
        step(); step();
        check_eq("rst_in_ready", in_ready, 0);
        check_eq("rst_dot_rst_n", dot_rst_n, 0);
        check_eq("rst_dot_start", dot_start, 0);
        check_eq("rst_res_valid", res_valid, 0);
        check_eq("rst_res_data", res_data, 0);
        check_eq("rst_dot_a", dot_a, 0);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_err", err_timeout, 0);
        rst_n = 1'b1;
        step();
        check_eq("post_rst_in_ready", in_ready, 1);
        check_eq("post_rst_dot_rst_n", dot_rst_n, 1);

        // 1: basic op, done 10 cycles into WAIT, short result stall.
        load_op({16{8'h01}}, {16{8'h02}}, 1'b0);
        check_eq("t1_dot_a", dot_a, {16{8'h01}});
        check_eq("t1_dot_b", dot_b, {16{8'h02}});
        check_eq("t1_busy", busy, 1);
        run_start("t1");
        repeat (9) step();
        check_eq("t1_wait_no_valid", res_valid, 0);
        dot_done = 1'b1; dot_c = 32'd32;
        step();
        dot_done = 1'b0; dot_c = 32'hffff_ffff;
        check_eq("t1_res_valid", res_valid, 1);
        check_eq("t1_res_data", res_data, 32);
        repeat (3) step();
        check_eq("t1_res_hold", res_data, 32);
        res_ready = 1'b1;
        step();
        res_ready = 1'b0;
        check_eq("t1_res_drop", res_valid, 0);
        wait_recover("t1");
        check_eq("t1_idle_busy", busy, 0);

        // 2: all-0xFF operands, ready already high when valid rises.
        res_ready = 1'b1;
        load_op({16{8'hff}}, {16{8'hff}}, 1'b0);
        run_start("t2");
        dot_c = stub_dot(dot_a, dot_b); dot_done = 1'b1;
        step();
        dot_done = 1'b0;
        check_eq("t2_res_valid", res_valid, 1);
        check_eq("t2_res_data", res_data, 32'd1040400);
        step();
        check_eq("t2_same_cycle_hs", res_valid, 0);
        res_ready = 1'b0;
        wait_recover("t2");

        // 3: random gaps, done held high from before loading, 20-cycle result stall.
        dot_done = 1'b1; dot_c = 32'd816;
        load_op(a3, b3, 1'b1);
        check_eq("t3_dot_a", dot_a, a3);
        check_eq("t3_dot_b", dot_b, b3);
        check_eq("t3_early_done_ignored", res_valid, 0);
        run_start("t3");
        check_eq("t3_wait_first", res_valid, 0);
        step();
        dot_done = 1'b0; dot_c = 32'hdead_beef;
        check_eq("t3_res_valid", res_valid, 1);
        check_eq("t3_res_data", res_data, 32'd816);
        in_valid = 1'b1; in_data = 32'h5a5a_5a5a;
        for (int i = 0; i < 20; i++) begin
            check_eq("t3_stall_in_ready", in_ready, 0);
            check_eq("t3_stall_valid", res_valid, 1);
            check_eq("t3_stall_data", res_data, 32'd816);
            step();
        end
        in_valid = 1'b0;
        res_ready = 1'b1;
        step();
        res_ready = 1'b0;
        wait_recover("t3");
        check_eq("t3_a_held", dot_a, a3);
        check_eq("t3_b_held", dot_b, b3);

        // 4: reset after 5 of 8 words, then a fresh op.
        n = start_rises;
        for (int k = 0; k < 5; k++) push(32'h1111_1111 * (k + 1), 0);
        check_eq("t4_partial_busy", busy, 1);
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        step();
        check_eq("t4_abort_no_start", start_rises, n);
        check_eq("t4_cleared_a", dot_a, 0);
        check_eq("t4_cleared_busy", busy, 0);
        load_op({16{8'h03}}, {16{8'h05}}, 1'b0);
        check_eq("t4_dot_a", dot_a, {16{8'h03}});
        check_eq("t4_dot_b", dot_b, {16{8'h05}});
        run_start("t4");
        dot_c = stub_dot(dot_a, dot_b); dot_done = 1'b1;
        step();
        dot_done = 1'b0;
        check_eq("t4_res_data", res_data, 32'd240);
        check_eq("t4_one_start", start_rises, n + 1);
        res_ready = 1'b1;
        step();
        res_ready = 1'b0;
        wait_recover("t4");

`ifdef DOT_LOADER_TIMEOUT_EN
        // 5: done never arrives; abort after 16 WAIT cycles, then a normal op.
        load_op({16{8'h01}}, {16{8'h01}}, 1'b0);
        run_start("t5");
        n = 0;
        while (!err_timeout && n < 100) begin
            n++;
            step();
        end
        check_eq("t5_timeout_cycles", n, 16);
        check_eq("t5_no_result", res_valid, 0);
        check_eq("t5_dot_rst_n", dot_rst_n, 0);
        wait_recover("t5");
        load_op({16{8'h01}}, {16{8'h01}}, 1'b0);
        run_start("t5b");
        dot_c = 32'd16; dot_done = 1'b1;
        step();
        dot_done = 1'b0;
        check_eq("t5_next_res", res_data, 32'd16);
        check_eq("t5_err_sticky", err_timeout, 1);
        res_ready = 1'b1;
        step();
        res_ready = 1'b0;
`else
        check_eq("t5_err_tied_low", err_timeout, 0);
`endif

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
